hw_pio_responder: RTL and testbench

- Hardware-side responder for the 2-bit PIO signal / 8-bit PIO data handshake driven by Nios software.
- Receives NBYTES bytes from software and hands them to a downstream core as one wide word (valid/ready).
- Accepts the core's wide result, then returns it to software byte by byte over the same handshake.
- Sits between the SoC PIO exports and the accelerator core, in the same clock domain as clk_clk.

---
 rtl/hw_pio_pkg.sv | 35 +++
 rtl/hw_pio_sync.sv | 26 ++
 rtl/hw_pio_responder.sv | 158 +++++++++++++++
 tb/tb_hw_pio_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hw_pio_pkg.sv
// rtl/hw_pio_pkg.sv - shared encodings and state type for the PIO responder
package hw_pio_pkg;

    localparam logic [1:0] SW_IDLE  = 2'b00;
    localparam logic [1:0] SW_WR    = 2'b01;
    localparam logic [1:0] SW_RD    = 2'b10;
    localparam logic [1:0] SW_ABORT = 2'b11;

    localparam logic [1:0] HW_IDLE  = 2'b00;
    localparam logic [1:0] HW_ACK   = 2'b01;
    localparam logic [1:0] HW_BUSY  = 2'b10;
    localparam logic [1:0] HW_ERR   = 2'b11;

    typedef enum logic [2:0] {
        ST_RX_WAIT   = 3'd0,
        ST_RX_ACK    = 3'd1,
        ST_HANDOFF   = 3'd2,
        ST_TX_WAIT   = 3'd3,
        ST_TX_IDLE   = 3'd4,
        ST_TX_ACK    = 3'd5,
        ST_ERR       = 3'd6,
        ST_ABORT_ACK = 3'd7
    } state_e;

    // Status shown to software while resident in a given state.
    function automatic logic [1:0] status_of(state_e s);
        case (s)
            ST_RX_ACK, ST_TX_ACK, ST_ABORT_ACK: return HW_ACK;
            ST_HANDOFF, ST_TX_WAIT:             return HW_BUSY;
            ST_ERR:                             return HW_ERR;
            default:                            return HW_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/hw_pio_sync.sv
// rtl/hw_pio_sync.sv - 2-flop synchroniser, used only when HW_PIO_SYNC_EN is defined
module hw_pio_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hw_pio_responder.sv
// rtl/hw_pio_responder.sv - PIO byte handshake <-> wide valid/ready word bridge; HW_PIO_SYNC_EN adds input synchronisers
module hw_pio_responder
    import hw_pio_pkg::*;
#(
    parameter int NBYTES = 16
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [7:0]            to_hw_port_export,
    input  logic [1:0]            to_hw_sig_export,
    output logic [7:0]            to_sw_port_export,
    output logic [1:0]            to_sw_sig_export,
    output logic [8*NBYTES-1:0]   rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [8*NBYTES-1:0]   tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    logic [1:0] cmd_sig;
    logic [7:0] cmd_data;

`ifdef HW_PIO_SYNC_EN
    hw_pio_sync #(.W(10)) u_sync (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .d_i    ({to_hw_sig_export, to_hw_port_export}),
        .q_o    ({cmd_sig, cmd_data})
    );
`else
    assign cmd_sig  = to_hw_sig_export;
    assign cmd_data = to_hw_port_export;
`endif

    state_e              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [8*NBYTES-1:0] rx_buf_q, rx_buf_d;
    logic [8*NBYTES-1:0] out_buf_q, out_buf_d;
    logic [7:0]          port_q, port_d;
    logic [1:0]          status_q, status_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_ready_q, tx_ready_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rx_buf_d  = rx_buf_q;
        out_buf_d = out_buf_q;
        port_d    = port_q;

        if (cmd_sig == SW_ABORT) begin
            state_d  = ST_ABORT_ACK;
            idx_d    = '0;
            rx_buf_d = '0;
            port_d   = '0;
        end else begin
            case (state_q)
                ST_RX_WAIT: begin
                    if (cmd_sig == SW_WR) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (idx_q == IDXW'(i)) rx_buf_d[8*(NBYTES-i)-1 -: 8] = cmd_data;
                        end
                        state_d = ST_RX_ACK;
                    end else if (cmd_sig == SW_RD) begin
                        state_d = ST_ERR;
                    end
                end
                ST_RX_ACK: begin
                    if (cmd_sig == SW_IDLE) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = ST_HANDOFF;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_RX_WAIT;
                        end
                    end
                end
                ST_HANDOFF: begin
                    if (rx_ready) state_d = ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (tx_valid) begin
                        out_buf_d = tx_data;
                        state_d   = ST_TX_IDLE;
                    end
                end
                ST_TX_IDLE: begin
                    if (cmd_sig == SW_RD) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (idx_q == IDXW'(i)) port_d = out_buf_q[8*(NBYTES-i)-1 -: 8];
                        end
                        state_d = ST_TX_ACK;
                    end else if (cmd_sig == SW_WR) begin
                        state_d = ST_ERR;
                    end
                end
                ST_TX_ACK: begin
                    if (cmd_sig == SW_IDLE) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            port_d  = '0;
                            state_d = ST_RX_WAIT;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_TX_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                ST_ABORT_ACK: begin
                    if (cmd_sig == SW_IDLE) state_d = ST_RX_WAIT;
                end
                default: state_d = ST_RX_WAIT;
            endcase
        end

        // Outputs are registered from the next state so they track it with one cycle of latency.
        status_d   = status_of(state_d);
        rx_valid_d = (state_d == ST_HANDOFF);
        tx_ready_d = (state_d == ST_TX_WAIT);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_RX_WAIT;
            idx_q      <= '0;
            rx_buf_q   <= '0;
            out_buf_q  <= '0;
            port_q     <= '0;
            status_q   <= HW_IDLE;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rx_buf_q   <= rx_buf_d;
            out_buf_q  <= out_buf_d;
            port_q     <= port_d;
            status_q   <= status_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign to_sw_port_export = port_q;
    assign to_sw_sig_export  = status_q;
    assign rx_data           = rx_buf_q;
    assign rx_valid          = rx_valid_q;
    assign tx_ready          = tx_ready_q;

endmodule

// File: tb/tb_hw_pio_responder.sv
// tb/tb_hw_pio_responder.sv - directed self-checking bench for hw_pio_responder
module tb_hw_pio_responder;

    localparam int N = 16;
`ifdef HW_PIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam logic [1:0] C_IDLE = 2'b00, C_WR = 2'b01, C_RD = 2'b10, C_ABORT = 2'b11;
    localparam logic [1:0] S_IDLE = 2'b00, S_ACK = 2'b01, S_BUSY = 2'b10, S_ERR = 2'b11;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     hw_port;
    logic [1:0]     hw_sig;
    logic [7:0]     sw_port;
    logic [1:0]     sw_sig;
    logic [8*N-1:0] rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [8*N-1:0] tx_data;
    logic           tx_valid;
    logic           tx_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hw_pio_responder #(.NBYTES(N)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .to_hw_port_export (hw_port),
        .to_hw_sig_export  (hw_sig),
        .to_sw_port_export (sw_port),
        .to_sw_sig_export  (sw_sig),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready)
    );

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        logic [1:0] exp_sig;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input logic [1:0] exp, input string name);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sw_sig == exp) break;
        end
        check(name, sw_sig, exp);
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit last);
        hw_port = b;
        hw_sig  = C_WR;
        wait_sig(S_ACK, "wr_ack");
        hw_sig  = C_IDLE;
        wait_sig(last ? S_BUSY : S_IDLE, last ? "wr_busy" : "wr_idle");
    endtask

    task automatic rd_byte(input logic [7:0] exp, input bit last);
        hw_sig = C_RD;
        wait_sig(S_ACK, "rd_ack");
        check("rd_data", sw_port, exp);
        hw_sig = C_IDLE;
        wait_sig(S_IDLE, "rd_idle");
        if (last) check("rd_port_cleared", sw_port, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_sig"}, sw_sig, 0);
        check({name, "_port"}, sw_port, 0);
        check({name, "_rx_valid"}, rx_valid, 0);
        check({name, "_tx_ready"}, tx_ready, 0);
        check({name, "_rx_data"}, rx_data, 0);
    endtask

    task automatic do_handoff_and_tx(input logic [127:0] word);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx_valid_drop", rx_valid, 0);
        check("tx_ready_up", tx_ready, 1);
        check("tx_wait_busy", sw_sig, S_BUSY);
        tx_data  = word;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = '0;
        check("tx_ready_drop", tx_ready, 0);
        check("tx_idle_sig", sw_sig, S_IDLE);
    endtask

    logic [127:0] exp_rx, exp_tx, exp_rx2, exp_rx3;

    initial begin
        tbl[0] = '{C_RD,    8'h00, S_ERR};
        tbl[1] = '{C_WR,    8'h55, S_ERR};
        tbl[2] = '{C_IDLE,  8'h00, S_ERR};
        tbl[3] = '{C_ABORT, 8'h00, S_ACK};
        tbl[4] = '{C_ABORT, 8'h00, S_ACK};
        tbl[5] = '{C_IDLE,  8'h00, S_IDLE};
        tbl[6] = '{C_WR,    8'hAA, S_ACK};
        tbl[7] = '{C_IDLE,  8'h00, S_IDLE};

        for (int i = 0; i < N; i++) begin
            exp_rx [8*(N-i)-1 -: 8] = 8'(i);
            exp_tx [8*(N-i)-1 -: 8] = 8'(((15 - i) << 4) | i);
            exp_rx2[8*(N-i)-1 -: 8] = 8'(8'h30 + i);
            exp_rx3[8*(N-i)-1 -: 8] = 8'(8'h80 + i);
        end

        rst_n = 1'b0; hw_port = '0; hw_sig = C_IDLE;
        rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
        #1;
        check_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_sig", sw_sig, S_IDLE);

        // Held WR: exact latency, single latch, ACK held throughout.
        hw_port = 8'h00;
        hw_sig  = C_WR;
        repeat (LAT - 1) tick();
        check("wr_latency_pre", sw_sig, S_IDLE);
        tick();
        check("wr_latency_ack", sw_sig, S_ACK);
        repeat (9) tick();
        check("wr_held_ack", sw_sig, S_ACK);
        hw_sig = C_IDLE;
        wait_sig(S_IDLE, "wr_held_release");
        for (int i = 1; i < N; i++) wr_byte(8'(i), i == N - 1);
        check("handoff_rx_valid", rx_valid, 1);
        check("handoff_rx_data", rx_data, exp_rx);

        hw_sig = C_WR;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_rx_data", rx_data, exp_rx);
            check("stall_rx_valid", rx_valid, 1);
            check("stall_busy", sw_sig, S_BUSY);
        end
        hw_sig = C_IDLE;
        repeat (LAT) tick();
        check("stall_busy_end", sw_sig, S_BUSY);

        do_handoff_and_tx(exp_tx);
        for (int i = 0; i < N; i++) rd_byte(exp_tx[8*(N-i)-1 -: 8], i == N - 1);

        // Error / abort sequence starting from RX_WAIT.
        for (int v = 0; v < 8; v++) begin
            hw_sig  = tbl[v].cmd;
            hw_port = tbl[v].data;
            repeat (LAT) tick();
            check($sformatf("tbl_%0d", v), sw_sig, tbl[v].exp_sig);
        end

        // Abort after 7 bytes, then a complete fresh word.
        for (int i = 1; i < 7; i++) wr_byte(8'hE0 + 8'(i), 1'b0);
        hw_sig = C_ABORT;
        wait_sig(S_ACK, "abort_ack");
        check("abort_rx_valid", rx_valid, 0);
        hw_sig = C_IDLE;
        wait_sig(S_IDLE, "abort_idle");
        for (int i = 0; i < N; i++) wr_byte(8'h30 + 8'(i), i == N - 1);
        check("fresh_rx_data", rx_data, exp_rx2);
        check("fresh_rx_valid", rx_valid, 1);

        // Asynchronous reset in the middle of TX_ACK.
        do_handoff_and_tx(exp_tx);
        hw_sig = C_RD;
        wait_sig(S_ACK, "pre_reset_ack");
        check("pre_reset_port", sw_port, 8'hF0);
        #2;
        rst_n  = 1'b0;
        hw_sig = C_IDLE;
        #1;
        check_all_zero("async_reset");
        #3;
        rst_n = 1'b1;
        tick();
        check("restart_sig", sw_sig, S_IDLE);
        for (int i = 0; i < N; i++) wr_byte(8'h80 + 8'(i), i == N - 1);
        check("restart_rx_data", rx_data, exp_rx3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
